if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_pkg.sv | 19 +
 rtl/if_stage_if.sv | 10 +
 rtl/if_stage_if_id_reg.sv | 34 +++
 rtl/if_stage.sv | 134 +++++++++++++
 tb/tb_if_stage.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/if_stage_pkg.sv
// Shared CPU package: fetch-stage reset/bubble constants and the fetch FSM encoding.
package if_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_REQ     = 2'd0,
        ST_WAIT    = 2'd1,
        ST_HOLD    = 2'd2,
        ST_DISCARD = 2'd3
    } fetch_state_t;

    // Fetch addresses are always word aligned.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction memory bus between the fetch stage (master) and the instruction memory (slave).
interface if_stage_if;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemValid;
    logic [31:0] IMemData;

    modport master (output IMemReq, output IMemAddr, input IMemValid, input IMemData);
    modport slave  (input IMemReq, input IMemAddr, output IMemValid, output IMemData);
endinterface

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: flush/bubble writes the NOP and clears valid, keeping PC_id.
import if_stage_pkg::*;

module if_id_reg #(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = if_stage_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic        flush,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    output logic [31:0] Instruction_id,
    output logic [31:0] PC_id,
    output logic        Valid_id
);

    always_ff @(posedge clk) begin
        if (reset) begin
            Instruction_id <= NOP_INSTR;
            PC_id          <= RESET_PC;
            Valid_id       <= 1'b0;
        end else if (flush) begin
            Instruction_id <= NOP_INSTR;
            Valid_id       <= 1'b0;
        end else if (we) begin
            Instruction_id <= instr_in;
            PC_id          <= pc_in;
            Valid_id       <= 1'b1;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding fetch, stall/redirect handling, feeds the IF/ID register.
//
// state   | meaning
// REQ     | issuing a fetch for pc this cycle
// WAIT    | fetch outstanding, waiting for IMemValid
// HOLD    | response captured during a stall, waiting for IFWrite
// DISCARD | redirected while a fetch is outstanding; drop its response
import if_stage_pkg::*;

module if_stage #(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = if_stage_pkg::NOP_INSTR
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           IFWrite,
    input  logic           Branch,
    input  logic           Jump,
    input  logic [31:0]    JumpAddr,
    if_stage_if.master     imem,
    output logic [31:0]    Instruction_id,
    output logic [31:0]    PC_id,
    output logic           Valid_id
);

    fetch_state_t state, state_nxt;
    logic [31:0]  pc, pc_nxt;
    logic [31:0]  hold_word;
    logic         hold_load;
    logic         redirect;
    logic         ifid_we, ifid_flush;
    logic [31:0]  ifid_instr;

    assign redirect      = (Branch | Jump) & IFWrite;
    assign imem.IMemReq  = (state == ST_REQ) & ~reset;
    assign imem.IMemAddr = pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_REQ;
            pc        <= align_pc(RESET_PC);
            hold_word <= 32'h0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (hold_load) hold_word <= imem.IMemData;
        end
    end

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        hold_load  = 1'b0;
        ifid_we    = 1'b0;
        ifid_flush = 1'b0;
        ifid_instr = imem.IMemData;

        // A bubble is the same register action as a flush.
        unique case (state)
            ST_REQ: begin
                if (redirect) begin
                    pc_nxt     = align_pc(JumpAddr);
                    ifid_flush = 1'b1;
                    state_nxt  = ST_DISCARD;
                end else begin
                    ifid_flush = IFWrite;
                    state_nxt  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem.IMemValid) begin
                    if (redirect) begin
                        pc_nxt     = align_pc(JumpAddr);
                        ifid_flush = 1'b1;
                        state_nxt  = ST_REQ;
                    end else if (IFWrite) begin
                        ifid_we   = 1'b1;
                        pc_nxt    = pc + 32'd4;
                        state_nxt = ST_REQ;
                    end else begin
                        hold_load = 1'b1;
                        state_nxt = ST_HOLD;
                    end
                end else if (redirect) begin
                    pc_nxt     = align_pc(JumpAddr);
                    ifid_flush = 1'b1;
                    state_nxt  = ST_DISCARD;
                end else begin
                    ifid_flush = IFWrite;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    pc_nxt     = align_pc(JumpAddr);
                    ifid_flush = 1'b1;
                    state_nxt  = ST_REQ;
                end else if (IFWrite) begin
                    ifid_we    = 1'b1;
                    ifid_instr = hold_word;
                    pc_nxt     = pc + 32'd4;
                    state_nxt  = ST_REQ;
                end
            end
            ST_DISCARD: begin
                // A redirect landing with the response must not wait for another response.
                if (redirect) begin
                    pc_nxt     = align_pc(JumpAddr);
                    ifid_flush = 1'b1;
                    state_nxt  = imem.IMemValid ? ST_REQ : ST_DISCARD;
                end else begin
                    ifid_flush = IFWrite;
                    if (imem.IMemValid) state_nxt = ST_REQ;
                end
            end
            default: state_nxt = ST_REQ;
        endcase
    end

    if_id_reg #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk            (clk),
        .reset          (reset),
        .we             (ifid_we),
        .flush          (ifid_flush),
        .instr_in       (ifid_instr),
        .pc_in          (pc),
        .Instruction_id (Instruction_id),
        .PC_id          (PC_id),
        .Valid_id       (Valid_id)
    );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: fetch, stall/hold, jump, ignored branch, PC wrap and reset cases.
import if_stage_pkg::*;

module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        IFWrite;
    logic        Branch;
    logic        Jump;
    logic [31:0] JumpAddr;
    logic [31:0] Instruction_id;
    logic [31:0] PC_id;
    logic        Valid_id;

    int n_vec  = 0;
    int n_miss = 0;

    if_stage_if imem_bus ();

    if_stage dut (
        .clk            (clk),
        .reset          (reset),
        .IFWrite        (IFWrite),
        .Branch         (Branch),
        .Jump           (Jump),
        .JumpAddr       (JumpAddr),
        .imem           (imem_bus),
        .Instruction_id (Instruction_id),
        .PC_id          (PC_id),
        .Valid_id       (Valid_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %08h, want %08h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resp(input logic v, input logic [31:0] d);
        imem_bus.IMemValid = v;
        imem_bus.IMemData  = d;
    endtask

    initial begin
        reset = 1'b1; IFWrite = 1'b1; Branch = 1'b0; Jump = 1'b0; JumpAddr = 32'h0;
        resp(1'b0, 32'h0);
        tick(); tick();
        chk("rst_req",   32'(imem_bus.IMemReq), 32'd0);
        chk("rst_valid", 32'(Valid_id), 32'd0);
        chk("rst_instr", Instruction_id, 32'h0000_0013);
        chk("rst_pcid",  PC_id, 32'h0);

        // first fetch, 1-cycle memory
        #1 reset = 1'b0;
        #1;
        chk("f0_req",  32'(imem_bus.IMemReq), 32'd1);
        chk("f0_addr", imem_bus.IMemAddr, 32'h0);
        tick();
        resp(1'b1, 32'h0050_0093);
        chk("f0_wait_req", 32'(imem_bus.IMemReq), 32'd0);
        tick();
        resp(1'b0, 32'h0);
        chk("f0_instr", Instruction_id, 32'h0050_0093);
        chk("f0_pcid",  PC_id, 32'h0);
        chk("f0_valid", 32'(Valid_id), 32'd1);
        chk("f0_next",  imem_bus.IMemAddr, 32'h4);

        // fetch at 0x4
        tick();
        resp(1'b1, 32'h0020_0093);
        tick();
        resp(1'b0, 32'h0);
        chk("f1_pcid",  PC_id, 32'h4);
        chk("f1_instr", Instruction_id, 32'h0020_0093);

        // stall coincident with response at 0x8
        tick();
        chk("bub_valid", 32'(Valid_id), 32'd0);
        IFWrite = 1'b0;
        resp(1'b1, 32'h00A0_0113);
        tick();
        resp(1'b0, 32'h0);
        tick(); tick();
        chk("hold_state", 32'(dut.state), 32'(ST_HOLD));
        chk("hold_instr", Instruction_id, 32'h0000_0013);
        chk("hold_pcid",  PC_id, 32'h4);
        chk("hold_valid", 32'(Valid_id), 32'd0);
        IFWrite = 1'b1;
        tick();
        chk("rel_instr", Instruction_id, 32'h00A0_0113);
        chk("rel_pcid",  PC_id, 32'h8);
        chk("rel_valid", 32'(Valid_id), 32'd1);
        chk("rel_next",  imem_bus.IMemAddr, 32'hC);

        // jump while waiting, no response yet
        tick();
        Jump = 1'b1; JumpAddr = 32'h100;
        tick();
        Jump = 1'b0;
        chk("jmp_valid", 32'(Valid_id), 32'd0);
        chk("jmp_instr", Instruction_id, 32'h0000_0013);
        chk("jmp_state", 32'(dut.state), 32'(ST_DISCARD));
        chk("jmp_noreq", 32'(imem_bus.IMemReq), 32'd0);
        resp(1'b1, 32'hDEAD_BEEF);
        tick();
        resp(1'b0, 32'h0);
        chk("jmp_req",   32'(imem_bus.IMemReq), 32'd1);
        chk("jmp_addr",  imem_bus.IMemAddr, 32'h100);
        chk("jmp_drop",  32'(Valid_id), 32'd0);

        // branch during stall is ignored
        IFWrite = 1'b0; Branch = 1'b1; JumpAddr = 32'h43;
        tick();
        Branch = 1'b0; IFWrite = 1'b1;
        resp(1'b1, 32'h1111_1111);
        tick();
        resp(1'b0, 32'h0);
        chk("brign_pcid", PC_id, 32'h100);
        chk("brign_addr", imem_bus.IMemAddr, 32'h104);
        // same branch with IFWrite=1 is taken, target aligned
        Branch = 1'b1; JumpAddr = 32'h43;
        tick();
        Branch = 1'b0;
        resp(1'b1, 32'h0);
        tick();
        resp(1'b0, 32'h0);
        chk("br_addr", imem_bus.IMemAddr, 32'h40);

        // redirect to top of memory, re-redirect in DISCARD, wrap on fetch
        Jump = 1'b1; JumpAddr = 32'hFFFF_FFFF;
        tick();
        JumpAddr = 32'hFFFF_FFFE;
        tick();
        Jump = 1'b0;
        chk("dis_stay", 32'(dut.state), 32'(ST_DISCARD));
        resp(1'b1, 32'h0);
        tick();
        resp(1'b0, 32'h0);
        chk("top_addr", imem_bus.IMemAddr, 32'hFFFF_FFFC);
        tick();
        resp(1'b1, 32'h2222_2222);
        tick();
        resp(1'b0, 32'h0);
        chk("wrap_pcid", PC_id, 32'hFFFF_FFFC);
        chk("wrap_addr", imem_bus.IMemAddr, 32'h0);

        // reset while in HOLD
        tick();
        IFWrite = 1'b0;
        resp(1'b1, 32'h4444_4444);
        tick();
        resp(1'b0, 32'h0);
        chk("pre_rst_state", 32'(dut.state), 32'(ST_HOLD));
        reset = 1'b1;
        tick();
        chk("hrst_state", 32'(dut.state), 32'(ST_REQ));
        chk("hrst_valid", 32'(Valid_id), 32'd0);
        chk("hrst_instr", Instruction_id, 32'h0000_0013);
        chk("hrst_addr",  imem_bus.IMemAddr, 32'h0);
        chk("hrst_noreq", 32'(imem_bus.IMemReq), 32'd0);

        // late response in first post-reset cycle is ignored
        reset = 1'b0; IFWrite = 1'b1;
        resp(1'b1, 32'h3333_3333);
        tick();
        resp(1'b1, 32'h0050_0093);
        tick();
        resp(1'b0, 32'h0);
        chk("late_instr", Instruction_id, 32'h0050_0093);
        chk("late_pcid",  PC_id, 32'h0);
        chk("late_next",  imem_bus.IMemAddr, 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
